alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Multi-cycle controller that executes one register-to-register ALU instruction at a time
//  against the 32x8 register file.
//  Per instruction: reads operand A, reads operand B, computes ADD/SUB/CMP/INC and writes back.
//  Updates the 4-bit flag register.
//  Sits between the instruction source (valid/ready) and the register file's address/read/write ports.
// PARAMETERS
//  DATA_W  8  register/ALU data width
//  ADDR_W  5  register address width (32 registers)
// PORTS
//  clk          in   1       single clock, all state on rising edge
//  rst          in   1       asynchronous, active-high reset
//  instr_valid  in   1       instruction present on instr_* fields
//  instr_ready  out  1       sequencer can accept an instruction (IDLE only)
//  instr_op     in   2       00 ADD, 01 SUB, 10 CMP, 11 INC
//  instr_ra     in   ADDR_W  operand A register
//  instr_rb     in   ADDR_W  operand B register (ignored for INC)
//  instr_rd     in   ADDR_W  destination register (ignored for CMP)
//  rf_addr      out  ADDR_W  register file address
//  rf_re        out  1       register file read strobe; rf_rdata valid the following cycle
//  rf_rdata     in   DATA_W  register file read data
//  rf_we        out  1       register file write strobe (one cycle)
//  rf_wdata     out  DATA_W  register file write data
//  flags        out  4       [0] overflow, [1] carry/borrow, [2] zero, [3] compare-true
//  busy         out  1       high in every state except IDLE
//  done         out  1       one-cycle pulse in WB state
// BEHAVIOUR
//  Reset (async, any state):
//   - state=IDLE, flags=0, all rf_* outputs=0, done=0, busy=0.
//   - Captured operands and instruction cleared; in-flight instruction dropped, no write.
//  FSM: IDLE -> RD_A -> RD_B -> EXEC -> WB -> IDLE; fixed, no stalls.
//   - IDLE: instr_ready=1. On instr_valid&instr_ready, latch op/ra/rb/rd; go RD_A.
//   - RD_A: rf_re=1, rf_addr=ra.
//   - RD_B: A<=rf_rdata; rf_re=1, rf_addr=rb (issued for INC too, data unused).
//   - EXEC: B<=rf_rdata; compute result and flags into registers.
//   - WB: done=1; rf_we=1 (0 for CMP), rf_addr=rd, rf_wdata=result; flags updated at end of WB.
//  Latency: accept edge T; done high in cycle T+4; next accept earliest cycle T+5.
//  Throughput: 1 instruction per 5 cycles.
//  rf_re/rf_we never both high; rf_addr=0 when neither strobe is asserted.
//  Arithmetic (unsigned 9-bit internal, result = low 8 bits):
//   - ADD: {C,R}=A+B; V=(A7==B7)&(R7!=A7).
//   - SUB: R=A-B; C=borrow (A<B); V=(A7!=B7)&(R7!=A7).
//   - INC: R=A+1; C=(A==8'hFF); V=(A==8'h7F).
//   - ADD/SUB/INC write flags[2:0] with Z=(R==0); flags[3] unchanged.
//   - CMP: flags[3]=(A>B) unsigned; flags[2:0] unchanged; no register write.
//  Hazards:
//   - rd==ra or rd==rb is legal: both reads complete before the write.
//   - ra==rb reads the same register twice.
//   - instr_valid outside IDLE is ignored (ready=0); source holds the instruction until accepted.
//   - Reset asserted during WB suppresses the write if it takes effect before the clock edge.
// TESTING
//  1. R0=8'h10, R1=8'h22; ADD rd=2 -> done at accept+4; R2=8'h32; flags=4'b0000.
//  2. R0=8'hFF, R1=8'h01; ADD rd=3 -> R3=8'h00; C=1, Z=1, V=0.
//  3. R4=8'h05, R5=8'h03; CMP -> flags[3]=1, no rf_we pulse.
//     Then R4=8'h03, R5=8'h05; CMP -> flags[3]=0; flags[2:0] preserved.
//  4. R0=8'h7F; INC rd=0 (in-place) -> R0=8'h80, V=1, C=0, Z=0.
//     Then SUB R0-R1 with R1=8'h81 -> R=8'hFF, C=1.
//  5. Hold instr_valid high with 3 back-to-back instructions -> accepts 5 cycles apart.
//     instr_ready low during RD_A..WB; done pulses exactly 3 times.
//  6. Assert rst mid-RD_B -> busy=0, flags=0 immediately; no rf_we.
//     Instruction lost; next instruction executes normally.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Instruction handshake and register-file port bundle for alu_op_sequencer.
// master = sequencer side, slave = instruction source / register file side.
interface alu_op_sequencer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
);
  logic              instr_valid;
  logic              instr_ready;
  logic [1:0]        instr_op;
  logic [ADDR_W-1:0] instr_ra;
  logic [ADDR_W-1:0] instr_rb;
  logic [ADDR_W-1:0] instr_rd;
  logic [ADDR_W-1:0] rf_addr;
  logic              rf_re;
  logic [DATA_W-1:0] rf_rdata;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic [3:0]        flags;
  logic              busy;
  logic              done;

  modport master (
    input  instr_valid, instr_op, instr_ra, instr_rb, instr_rd, rf_rdata,
    output instr_ready, rf_addr, rf_re, rf_we, rf_wdata, flags, busy, done
  );

  modport slave (
    output instr_valid, instr_op, instr_ra, instr_rb, instr_rd, rf_rdata,
    input  instr_ready, rf_addr, rf_re, rf_we, rf_wdata, flags, busy, done
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller: reads A, reads B, computes ADD/SUB/CMP/INC and writes back
// one register-to-register instruction every five cycles, maintaining a 4-bit flag register.
module alu_op_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input logic                clk,
  input logic                rst,
  alu_op_sequencer_if.master bus
);
  localparam int unsigned MSB = DATA_W - 1;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_INC = 2'b11;
  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_B, S_EXEC, S_WB} state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_rb, r_rd;
  logic [DATA_W-1:0] r_a;
  logic [3:0]        r_flags, r_flags_pend;
  logic [ADDR_W-1:0] r_rf_addr;
  logic              r_rf_re, r_rf_we;
  logic [DATA_W-1:0] r_rf_wdata;
  logic              r_busy, r_done, r_ready;

  logic [ADDR_W-1:0] w_rf_addr_nxt;
  logic              w_rf_re_nxt, w_rf_we_nxt;
  logic [DATA_W-1:0] w_rf_wdata_nxt;
  logic              w_busy_nxt, w_done_nxt, w_ready_nxt, w_accept;
  logic [3:0]        w_flags_nxt, w_flags_calc;
  logic [DATA_W:0]   w_sum, w_diff, w_inc;
  logic [DATA_W-1:0] w_b, w_result;

  assign bus.instr_ready = r_ready;
  assign bus.rf_addr     = r_rf_addr;
  assign bus.rf_re       = r_rf_re;
  assign bus.rf_we       = r_rf_we;
  assign bus.rf_wdata    = r_rf_wdata;
  assign bus.flags       = r_flags;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

  // Operand B is consumed straight off the read port during EXEC
  assign w_b    = bus.rf_rdata;
  assign w_sum  = {1'b0, r_a} + {1'b0, w_b};
  assign w_diff = {1'b0, r_a} - {1'b0, w_b};
  assign w_inc  = {1'b0, r_a} + {{DATA_W{1'b0}}, 1'b1};

  // ALU result and candidate flags; CMP only touches the compare bit
  always_comb begin
    w_result     = '0;
    w_flags_calc = r_flags;
    case (r_op)
      OP_ADD: begin
        w_result        = w_sum[DATA_W-1:0];
        w_flags_calc[1] = w_sum[DATA_W];
        w_flags_calc[0] = (r_a[MSB] == w_b[MSB]) && (w_result[MSB] != r_a[MSB]);
        w_flags_calc[2] = (w_result == '0);
      end
      OP_SUB: begin
        w_result        = w_diff[DATA_W-1:0];
        w_flags_calc[1] = w_diff[DATA_W];
        w_flags_calc[0] = (r_a[MSB] != w_b[MSB]) && (w_result[MSB] != r_a[MSB]);
        w_flags_calc[2] = (w_result == '0);
      end
      OP_INC: begin
        w_result        = w_inc[DATA_W-1:0];
        w_flags_calc[1] = w_inc[DATA_W];
        w_flags_calc[0] = (r_a == MAX_POS);
        w_flags_calc[2] = (w_result == '0);
      end
      default: w_flags_calc[3] = (r_a > w_b);
    endcase
  end

  // Next state plus the values the registered outputs take in that state
  always_comb begin
    w_state_nxt    = r_state;
    w_rf_addr_nxt  = '0;
    w_rf_re_nxt    = 1'b0;
    w_rf_we_nxt    = 1'b0;
    w_rf_wdata_nxt = '0;
    w_busy_nxt     = 1'b1;
    w_done_nxt     = 1'b0;
    w_ready_nxt    = 1'b0;
    w_flags_nxt    = r_flags;
    w_accept       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.instr_valid) begin
          w_accept      = 1'b1;
          w_state_nxt   = S_RD_A;
          w_rf_re_nxt   = 1'b1;
          w_rf_addr_nxt = bus.instr_ra;
        end else begin
          w_busy_nxt  = 1'b0;
          w_ready_nxt = 1'b1;
        end
      end
      S_RD_A: begin
        w_state_nxt   = S_RD_B;
        w_rf_re_nxt   = 1'b1;
        w_rf_addr_nxt = r_rb;
      end
      S_RD_B: w_state_nxt = S_EXEC;
      S_EXEC: begin
        w_state_nxt = S_WB;
        w_done_nxt  = 1'b1;
        if (r_op != OP_CMP) begin
          w_rf_we_nxt    = 1'b1;
          w_rf_addr_nxt  = r_rd;
          w_rf_wdata_nxt = w_result;
        end
      end
      S_WB: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_ready_nxt = 1'b1;
        w_flags_nxt = r_flags_pend;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_op         <= '0;
      r_rb         <= '0;
      r_rd         <= '0;
      r_a          <= '0;
      r_flags      <= '0;
      r_flags_pend <= '0;
      r_rf_addr    <= '0;
      r_rf_re      <= 1'b0;
      r_rf_we      <= 1'b0;
      r_rf_wdata   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_ready      <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_rf_addr  <= w_rf_addr_nxt;
      r_rf_re    <= w_rf_re_nxt;
      r_rf_we    <= w_rf_we_nxt;
      r_rf_wdata <= w_rf_wdata_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_ready    <= w_ready_nxt;
      r_flags    <= w_flags_nxt;
      if (w_accept) begin
        r_op <= bus.instr_op;
        r_rb <= bus.instr_rb;
        r_rd <= bus.instr_rd;
      end
      if (r_state == S_RD_B) r_a <= bus.rf_rdata;
      if (r_state == S_EXEC) r_flags_pend <= w_flags_calc;
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: register file model, directed scenarios
// and randomized instructions checked against an integer-arithmetic reference model.
module tb_alu_op_sequencer;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  alu_op_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  logic [7:0] mem [32];
  logic [7:0] ref_mem [32];
  logic [3:0] ref_flags = 4'h0;
  logic       pre_we = 1'b0;
  logic [4:0] pre_addr = '0;
  logic [7:0] pre_data = '0;
  int cyc = 0, we_pulses = 0, done_pulses = 0, viol = 0;
  int acc_q[$];
  int n_checks = 0, n_errors = 0;

  // Register file: synchronous read (data next cycle), synchronous write, bench preload port
  always @(posedge clk) begin
    cyc++;
    if (bus.instr_valid && bus.instr_ready) acc_q.push_back(cyc);
    if (bus.done) done_pulses++;
    if (bus.rf_we) we_pulses++;
    if (pre_we) mem[pre_addr] <= pre_data;
    if (bus.rf_we) mem[bus.rf_addr] <= bus.rf_wdata;
    if (bus.rf_re) bus.rf_rdata <= mem[bus.rf_addr];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rf_re && bus.rf_we) viol++;
      if (!bus.rf_re && !bus.rf_we && bus.rf_addr != '0) viol++;
      if (bus.instr_ready == bus.busy) viol++;
    end
  end

  // Reference: returns {flags, result} using whole-number arithmetic
  function automatic logic [11:0] alu_ref(input logic [1:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [3:0] fin);
    int ua, ub, sa, sb, ur, sr;
    logic [7:0] r;
    logic [3:0] f;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    f = fin; r = 8'h00;
    case (op)
      2'd0:    begin ur = ua + ub; sr = sa + sb; end
      2'd1:    begin ur = ua - ub; sr = sa - sb; end
      2'd3:    begin ur = ua + 1;  sr = sa + 1;  end
      default: begin ur = 0;       sr = 0;       end
    endcase
    if (op == 2'd2) begin
      f[3] = (ua > ub);
    end else begin
      r    = 8'(ur);
      f[0] = (sr > 127) || (sr < -128);
      f[1] = (op == 2'd1) ? (ua < ub) : (ur > 255);
      f[2] = (r == 8'h00);
    end
    return {f, r};
  endfunction

  task automatic set_reg(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic run_instr(input logic [1:0] op, input logic [4:0] ra, input logic [4:0] rb,
                           input logic [4:0] rd, output int lat, output int wes, output bit to);
    logic [11:0] e;
    int w0, n;
    e = alu_ref(op, ref_mem[ra], ref_mem[rb], ref_flags);
    to = 1'b0; lat = 0; wes = 0;
    @(negedge clk);
    bus.instr_valid = 1'b1; bus.instr_op = op;
    bus.instr_ra = ra; bus.instr_rb = rb; bus.instr_rd = rd;
    n = 0;
    while (!bus.instr_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.instr_ready) begin to = 1'b1; bus.instr_valid = 1'b0; return; end
    @(posedge clk);
    w0 = we_pulses;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    lat = 1;
    while (!bus.done && lat < 10) begin @(negedge clk); lat++; end
    if (!bus.done) to = 1'b1;
    @(negedge clk);
    wes = we_pulses - w0;
    ref_flags = e[11:8];
    if (op != 2'd2) ref_mem[rd] = e[7:0];
  endtask

  task automatic test_reset();
    logic [30:0] got;
    @(negedge clk);
    got = {bus.busy, bus.done, bus.flags, bus.rf_re, bus.rf_we, bus.rf_addr, bus.rf_wdata,
           bus.instr_ready, 8'h00};
    n_checks++;
    if (got !== {1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 8'h00}) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h expected %h", got,
               {1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 8'h00});
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    int lat, wes; bit to;
    set_reg(0, 8'h10); set_reg(1, 8'h22);
    run_instr(2'd0, 0, 1, 2, lat, wes, to);
    n_checks++; if (to !== 1'b0 || lat != 4) begin n_errors++; $display("FAIL add_latency: got %0d expected 4 (timeout=%0d)", lat, to); end
    n_checks++; if (mem[2] !== 8'h32) begin n_errors++; $display("FAIL add_result: got %h expected 32", mem[2]); end
    n_checks++; if (bus.flags !== 4'b0000) begin n_errors++; $display("FAIL add_flags: got %b expected 0000", bus.flags); end
    n_checks++; if (wes != 1) begin n_errors++; $display("FAIL add_we_count: got %0d expected 1", wes); end
    set_reg(0, 8'hFF); set_reg(1, 8'h01);
    run_instr(2'd0, 0, 1, 3, lat, wes, to);
    n_checks++; if (mem[3] !== 8'h00) begin n_errors++; $display("FAIL add_wrap_result: got %h expected 00", mem[3]); end
    n_checks++; if (bus.flags !== 4'b0110) begin n_errors++; $display("FAIL add_wrap_flags: got %b expected 0110", bus.flags); end
  endtask

  task automatic test_cmp();
    int lat, wes; bit to;
    set_reg(4, 8'h05); set_reg(5, 8'h03); set_reg(7, 8'hA5);
    run_instr(2'd2, 4, 5, 7, lat, wes, to);
    n_checks++; if (bus.flags !== 4'b1110) begin n_errors++; $display("FAIL cmp_gt_flags: got %b expected 1110", bus.flags); end
    n_checks++; if (wes != 0 || to) begin n_errors++; $display("FAIL cmp_no_write: got %0d writes expected 0", wes); end
    n_checks++; if (mem[7] !== 8'hA5) begin n_errors++; $display("FAIL cmp_rd_untouched: got %h expected a5", mem[7]); end
    set_reg(4, 8'h03); set_reg(5, 8'h05);
    run_instr(2'd2, 4, 5, 7, lat, wes, to);
    n_checks++; if (bus.flags !== 4'b0110) begin n_errors++; $display("FAIL cmp_lt_flags: got %b expected 0110", bus.flags); end
  endtask

  task automatic test_inc_sub();
    int lat, wes; bit to;
    set_reg(0, 8'h7F);
    run_instr(2'd3, 0, 9, 0, lat, wes, to);
    n_checks++; if (mem[0] !== 8'h80) begin n_errors++; $display("FAIL inc_inplace_result: got %h expected 80", mem[0]); end
    n_checks++; if (bus.flags !== 4'b0001) begin n_errors++; $display("FAIL inc_flags: got %b expected 0001", bus.flags); end
    set_reg(1, 8'h81);
    run_instr(2'd1, 0, 1, 6, lat, wes, to);
    n_checks++; if (mem[6] !== 8'hFF) begin n_errors++; $display("FAIL sub_result: got %h expected ff", mem[6]); end
    n_checks++; if (bus.flags !== 4'b0010) begin n_errors++; $display("FAIL sub_flags: got %b expected 0010", bus.flags); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops [3];
    logic [4:0]  ras [3], rbs [3], rds [3];
    logic [11:0] e;
    int d0, n;
    bit to;
    ops[0] = 2'd0; ras[0] = 7; rbs[0] = 8; rds[0] = 6;
    ops[1] = 2'd1; ras[1] = 6; rbs[1] = 7; rds[1] = 9;
    ops[2] = 2'd3; ras[2] = 6; rbs[2] = 6; rds[2] = 6;
    set_reg(7, 8'h40); set_reg(8, 8'h50); set_reg(6, 8'h00);
    acc_q.delete();
    d0 = done_pulses; to = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      bus.instr_valid = 1'b1; bus.instr_op = ops[k];
      bus.instr_ra = ras[k]; bus.instr_rb = rbs[k]; bus.instr_rd = rds[k];
      n = 0;
      while (!bus.instr_ready && n < 20) begin @(negedge clk); n++; end
      if (!bus.instr_ready) to = 1'b1;
      @(posedge clk);
      e = alu_ref(ops[k], ref_mem[ras[k]], ref_mem[rbs[k]], ref_flags);
      ref_flags = e[11:8];
      if (ops[k] != 2'd2) ref_mem[rds[k]] = e[7:0];
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++;
    if (to || acc_q.size() != 3) begin
      n_errors++; $display("FAIL b2b_accepts: got %0d accepts expected 3", acc_q.size());
    end else begin
      n_checks++; if (acc_q[1] - acc_q[0] != 5) begin n_errors++; $display("FAIL b2b_spacing_01: got %0d expected 5", acc_q[1] - acc_q[0]); end
      n_checks++; if (acc_q[2] - acc_q[1] != 5) begin n_errors++; $display("FAIL b2b_spacing_12: got %0d expected 5", acc_q[2] - acc_q[1]); end
    end
    n_checks++; if (done_pulses - d0 != 3) begin n_errors++; $display("FAIL b2b_done_count: got %0d expected 3", done_pulses - d0); end
    n_checks++; if (mem[6] !== ref_mem[6]) begin n_errors++; $display("FAIL b2b_r6: got %h expected %h", mem[6], ref_mem[6]); end
    n_checks++; if (mem[9] !== ref_mem[9]) begin n_errors++; $display("FAIL b2b_r9: got %h expected %h", mem[9], ref_mem[9]); end
    n_checks++; if (bus.flags !== ref_flags) begin n_errors++; $display("FAIL b2b_flags: got %b expected %b", bus.flags, ref_flags); end
  endtask

  task automatic test_reset_mid();
    int lat, wes, w0, n; bit to;
    logic [8:0] got;
    set_reg(10, 8'h11); set_reg(11, 8'h22); set_reg(12, 8'h5A);
    @(negedge clk);
    bus.instr_valid = 1'b1; bus.instr_op = 2'd0;
    bus.instr_ra = 10; bus.instr_rb = 11; bus.instr_rd = 12;
    n = 0;
    while (!bus.instr_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    got = {bus.busy, bus.flags, bus.rf_we, bus.rf_re, bus.instr_ready, bus.done};
    n_checks++; if (got !== {1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0}) begin n_errors++; $display("FAIL rst_mid_outputs: got %b expected %b", got, {1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0}); end
    n_checks++; if (bus.rf_addr !== 5'h00) begin n_errors++; $display("FAIL rst_mid_addr: got %h expected 00", bus.rf_addr); end
    w0 = we_pulses;
    @(negedge clk);
    rst = 1'b0;
    ref_flags = 4'h0;
    repeat (6) @(negedge clk);
    n_checks++; if (mem[12] !== 8'h5A || we_pulses != w0) begin n_errors++; $display("FAIL rst_mid_no_write: got r12=%h writes=%0d expected 5a and 0", mem[12], we_pulses - w0); end
    run_instr(2'd0, 10, 11, 12, lat, wes, to);
    n_checks++; if (to || lat != 4 || mem[12] !== 8'h33) begin n_errors++; $display("FAIL rst_mid_next_instr: got r12=%h lat=%0d expected 33 and 4", mem[12], lat); end
    n_checks++; if (bus.flags !== 4'b0000) begin n_errors++; $display("FAIL rst_mid_next_flags: got %b expected 0000", bus.flags); end
  endtask

  task automatic test_random();
    int lat, wes; bit to;
    logic [1:0] op;
    logic [4:0] ra, rb, rd;
    for (int i = 0; i < 32; i++) set_reg(5'(i), 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      ra = 5'($urandom_range(0, 31));
      rb = (i % 5 == 0) ? ra : 5'($urandom_range(0, 31));
      rd = (i % 4 == 0) ? ra : 5'($urandom_range(0, 31));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_instr(op, ra, rb, rd, lat, wes, to);
      n_checks++; if (to || lat != 4) begin n_errors++; $display("FAIL rand_latency[%0d]: got %0d expected 4", i, lat); end
      n_checks++; if (mem[rd] !== ref_mem[rd]) begin n_errors++; $display("FAIL rand_result[%0d] op=%0d: got %h expected %h", i, op, mem[rd], ref_mem[rd]); end
      n_checks++; if (bus.flags !== ref_flags) begin n_errors++; $display("FAIL rand_flags[%0d] op=%0d: got %b expected %b", i, op, bus.flags, ref_flags); end
      n_checks++; if (wes != ((op == 2'd2) ? 0 : 1)) begin n_errors++; $display("FAIL rand_we_count[%0d]: got %0d expected %0d", i, wes, (op == 2'd2) ? 0 : 1); end
    end
  endtask

  task automatic test_protocol();
    n_checks++;
    if (viol != 0) begin n_errors++; $display("FAIL protocol_violations: got %0d expected 0", viol); end
  endtask

  initial begin
    bus.instr_valid = 1'b0; bus.instr_op = 2'd0;
    bus.instr_ra = '0; bus.instr_rb = '0; bus.instr_rd = '0;
    test_reset();
    test_add();
    test_cmp();
    test_inc_sub();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
